// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: request/command toward the arbiter,
// grant and read-return back toward the requester.
interface mem_arbiter_if;
   logic        req;
   logic [15:0] addr;
   logic        we;
   logic [7:0]  wdata;
   logic        gnt;
   logic        rvalid;
   logic [7:0]  rdata;

   modport master (output req, addr, we, wdata, input  gnt, rvalid, rdata);
   modport slave  (input  req, addr, we, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between the core (C) and a secondary master (D).
// C has fixed priority; D wins after STARVE consecutive lost arbitrations.
module mem_arbiter #(
   parameter int LATENCY = 1,
   parameter int STARVE  = 4
) (
   input  logic          CLOCK,
   input  logic          RESET,
   mem_arbiter_if.slave  c_if,
   mem_arbiter_if.slave  d_if,
   output logic [15:0]   MA,
   output logic [7:0]    MDO,
   output logic          MW,
   input  logic [7:0]    MDI
);

   typedef enum logic [1:0] {WIN_NONE, WIN_C, WIN_D} win_e;
   typedef struct packed {
      logic valid;
      logic port_d;
   } tag_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE);

   win_e        win;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [15:0] ma_q, ma_d;
   logic [7:0]  mdo_q, mdo_d;
   logic        mw_q, mw_d;
   tag_t        tag_q [LATENCY+1];
   tag_t        tag_d [LATENCY+1];
   logic        c_rvalid_q, c_rvalid_d;
   logic        d_rvalid_q, d_rvalid_d;
   logic [7:0]  c_rdata_q, c_rdata_d;
   logic [7:0]  d_rdata_q, d_rdata_d;

   always_comb begin
      win = WIN_NONE;
      if (!RESET) begin
         if (c_if.req && (!d_if.req || wait_cnt_q < STARVE_LIM)) win = WIN_C;
         else if (d_if.req)                                      win = WIN_D;
      end
   end

   assign c_if.gnt = (win == WIN_C);
   assign d_if.gnt = (win == WIN_D);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wait_cnt_d = '0;
      ma_d       = ma_q;
      mdo_d      = mdo_q;
      mw_d       = 1'b0;
      tag_d[0]   = '0;
      for (int k = 1; k <= LATENCY; k++) tag_d[k] = tag_q[k-1];

      if (d_if.req && win != WIN_D)
         wait_cnt_d = (wait_cnt_q >= STARVE_LIM) ? STARVE_LIM : wait_cnt_q + 4'd1;

      case (win)
         WIN_C: begin
            ma_d     = c_if.addr;
            mdo_d    = c_if.wdata;
            mw_d     = c_if.we;
            tag_d[0] = '{valid: !c_if.we, port_d: 1'b0};
         end
         WIN_D: begin
            ma_d     = d_if.addr;
            mdo_d    = d_if.wdata;
            mw_d     = d_if.we;
            tag_d[0] = '{valid: !d_if.we, port_d: 1'b1};
         end
         default: ;
      endcase

      // The tail entry lines up with MDI for the read it tracks.
      c_rvalid_d = tag_q[LATENCY].valid && !tag_q[LATENCY].port_d;
      d_rvalid_d = tag_q[LATENCY].valid &&  tag_q[LATENCY].port_d;
      c_rdata_d  = c_rvalid_d ? MDI : c_rdata_q;
      d_rdata_d  = d_rvalid_d ? MDI : d_rdata_q;
   end

   // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         wait_cnt_q <= '0;
         ma_q       <= '0;
         mdo_q      <= '0;
         mw_q       <= 1'b0;
         c_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         c_rdata_q  <= '0;
         d_rdata_q  <= '0;
         // NOTE: the tag array is tiny and must be cleared so in-flight reads are dropped on reset.
         for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         ma_q       <= ma_d;
         mdo_q      <= mdo_d;
         mw_q       <= mw_d;
         c_rvalid_q <= c_rvalid_d;
         d_rvalid_q <= d_rvalid_d;
         c_rdata_q  <= c_rdata_d;
         d_rdata_q  <= d_rdata_d;
         tag_q      <= tag_d;
      end
   end

   assign MA          = ma_q;
   assign MDO         = mdo_q;
   assign MW          = mw_q;
   assign c_if.rvalid = c_rvalid_q;
   assign c_if.rdata  = c_rdata_q;
   assign d_if.rvalid = d_rvalid_q;
   assign d_if.rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;
   localparam int LAT  = 2;
   localparam int STV  = 4;
   localparam int MAXC = 8192;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ma;
   logic [7:0]  mdo, mdi;
   logic        mw;

   always #5 clk = ~clk;

   mem_arbiter_if c_bus ();
   mem_arbiter_if d_bus ();

   mem_arbiter #(.LATENCY(LAT), .STARVE(STV)) dut (
      .CLOCK (clk),
      .RESET (rst),
      .c_if  (c_bus),
      .d_if  (d_bus),
      .MA    (ma),
      .MDO   (mdo),
      .MW    (mw),
      .MDI   (mdi)
   );

   // Background memory contents, with a few fixed bytes the directed tests rely on.
   function automatic logic [7:0] init_byte(input logic [15:0] a);
      case (a)
         16'h1234: return 8'hA5;
         16'h0010: return 8'h11;
         16'h0020: return 8'h22;
         default:  return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
      endcase
   endfunction

   // Write-first synchronous memory with LAT cycles of read latency.
   bit         written [65536];
   logic [7:0] wmem    [65536];
   logic [7:0] rd_pipe [LAT];

   function automatic logic [7:0] mem_read(input logic [15:0] a);
      return written[a] ? wmem[a] : init_byte(a);
   endfunction

   always @(posedge clk) begin
      if (mw) begin
         written[ma] <= 1'b1;
         wmem[ma]    <= mdo;
      end
      rd_pipe[0] <= mw ? mdo : mem_read(ma);
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mdi = rd_pipe[LAT-1];

   typedef struct packed {
      logic        req;
      logic [15:0] addr;
      logic        we;
      logic [7:0]  wdata;
   } rq_t;

   typedef struct {
      int         due;
      bit         port_d;
      logic [7:0] data;
   } ret_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Transaction-level model state.
   int         m_wait;
   logic [15:0] m_ma;
   logic [7:0]  m_mdo, m_crd, m_drd;
   logic        m_mw, m_crv, m_drv;
   ret_t        pend [$];
   bit          sh_w [65536];
   logic [7:0]  sh_m [65536];

   logic        log_c_gnt [MAXC];
   logic        log_d_gnt [MAXC];
   logic        log_c_rv  [MAXC];
   logic        log_d_rv  [MAXC];
   logic        log_mw    [MAXC];
   logic [15:0] log_ma    [MAXC];
   logic [7:0]  log_mdo   [MAXC];
   logic [7:0]  log_c_rd  [MAXC];
   logic [7:0]  log_d_rd  [MAXC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic rq_t rd(input logic [15:0] a);
      return '{req: 1'b1, addr: a, we: 1'b0, wdata: 8'h00};
   endfunction

   function automatic rq_t wr(input logic [15:0] a, input logic [7:0] d);
      return '{req: 1'b1, addr: a, we: 1'b1, wdata: d};
   endfunction

   function automatic logic [7:0] sh_read(input logic [15:0] a);
      return sh_w[a] ? sh_m[a] : init_byte(a);
   endfunction

   // Model: decide what the registered outputs must show in the next cycle.
   task automatic model_update(input rq_t c, input rq_t d, input logic r, input int win);
      rq_t  w;
      ret_t t;
      if (r) begin
         m_ma = '0; m_mdo = '0; m_mw = 1'b0;
         m_crv = 1'b0; m_drv = 1'b0; m_crd = '0; m_drd = '0;
         m_wait = 0;
         pend.delete();
         return;
      end
      if (win != 0) begin
         w     = (win == 1) ? c : d;
         m_ma  = w.addr;
         m_mdo = w.wdata;
         m_mw  = w.we;
         if (w.we) begin
            sh_w[w.addr] = 1'b1;
            sh_m[w.addr] = w.wdata;
         end else begin
            pend.push_back('{due: cyc + LAT + 2, port_d: (win == 2), data: sh_read(w.addr)});
         end
      end else begin
         m_mw = 1'b0;
      end
      m_crv = 1'b0;
      m_drv = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
         t = pend.pop_front();
         if (t.port_d) begin m_drv = 1'b1; m_drd = t.data; end
         else          begin m_crv = 1'b1; m_crd = t.data; end
      end
      // D's consecutive losses, capped at the starvation limit.
      if (d.req && win != 2) m_wait = (m_wait + 1 > STV) ? STV : m_wait + 1;
      else                   m_wait = 0;
   endtask

   // One clock cycle: drive, check grants, advance model, check registered outputs.
   task automatic step(input rq_t c, input rq_t d, input logic r, output int win);
      c_bus.req = c.req; c_bus.addr = c.addr; c_bus.we = c.we; c_bus.wdata = c.wdata;
      d_bus.req = d.req; d_bus.addr = d.addr; d_bus.we = d.we; d_bus.wdata = d.wdata;
      rst = r;
      #1;
      win = 0;
      if (!r) begin
         if (c.req && d.req) win = (m_wait >= STV) ? 2 : 1;
         else if (c.req)     win = 1;
         else if (d.req)     win = 2;
      end
      check("c_gnt", 32'(c_bus.gnt), 32'(win == 1));
      check("d_gnt", 32'(d_bus.gnt), 32'(win == 2));
      if (cyc < MAXC) begin
         log_c_gnt[cyc] = c_bus.gnt;
         log_d_gnt[cyc] = d_bus.gnt;
      end
      model_update(c, d, r, win);
      @(posedge clk);
      #1;
      cyc++;
      check("MA",       32'(ma),           32'(m_ma));
      check("MDO",      32'(mdo),          32'(m_mdo));
      check("MW",       32'(mw),           32'(m_mw));
      check("c_rvalid", 32'(c_bus.rvalid), 32'(m_crv));
      check("d_rvalid", 32'(d_bus.rvalid), 32'(m_drv));
      check("c_rdata",  32'(c_bus.rdata),  32'(m_crd));
      check("d_rdata",  32'(d_bus.rdata),  32'(m_drd));
      if (cyc < MAXC) begin
         log_c_rv[cyc] = c_bus.rvalid; log_d_rv[cyc] = d_bus.rvalid;
         log_c_rd[cyc] = c_bus.rdata;  log_d_rd[cyc] = d_bus.rdata;
         log_mw[cyc]   = mw; log_ma[cyc] = ma; log_mdo[cyc] = mdo;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rq_t idle;
      rq_t cq, dq;
      int  w, t0;
      logic r;
      idle   = '0;
      m_wait = 0;

      step(idle, idle, 1'b1, w);
      step(idle, idle, 1'b1, w);
      check("lit_reset_MA",      32'(log_ma[cyc]),   32'h0);
      check("lit_reset_c_rdata", 32'(log_c_rd[cyc]), 32'h0);

      // Core read of 0x1234 returns 0xA5 LAT+2 cycles after grant.
      t0 = cyc;
      step(rd(16'h1234), idle, 1'b0, w);
      repeat (6) step(idle, idle, 1'b0, w);
      check("lit_rd_gnt",   32'(log_c_gnt[t0]),     32'h1);
      check("lit_rd_MA",    32'(log_ma[t0+1]),      32'h1234);
      check("lit_rd_MW",    32'(log_mw[t0+1]),      32'h0);
      check("lit_rd_early", 32'(log_c_rv[t0+LAT+1]), 32'h0);
      check("lit_rd_rv",    32'(log_c_rv[t0+LAT+2]), 32'h1);
      check("lit_rd_data",  32'(log_c_rd[t0+LAT+2]), 32'hA5);
      check("lit_rd_late",  32'(log_c_rv[t0+LAT+3]), 32'h0);
      for (int i = 1; i <= 6; i++) check("lit_rd_no_d", 32'(log_d_rv[t0+i]), 32'h0);

      // Contention: C wins four times, then D once, repeating.
      t0 = cyc;
      repeat (10) step(rd(16'h0100), rd(16'h0200), 1'b0, w);
      for (int i = 0; i < 10; i++) begin
         check("lit_cont_c", 32'(log_c_gnt[t0+i]), 32'(!(i == 4 || i == 9)));
         check("lit_cont_d", 32'(log_d_gnt[t0+i]), 32'(i == 4 || i == 9));
      end
      repeat (6) step(idle, idle, 1'b0, w);

      // Interleaved reads from both ports return in issue order.
      t0 = cyc;
      step(rd(16'h0010), idle, 1'b0, w);
      step(idle, rd(16'h0020), 1'b0, w);
      repeat (6) step(idle, idle, 1'b0, w);
      check("lit_mix_c_rv", 32'(log_c_rv[t0+LAT+2]), 32'h1);
      check("lit_mix_c_rd", 32'(log_c_rd[t0+LAT+2]), 32'h11);
      check("lit_mix_d_rv", 32'(log_d_rv[t0+LAT+3]), 32'h1);
      check("lit_mix_d_rd", 32'(log_d_rd[t0+LAT+3]), 32'h22);

      // D writes then reads the same address.
      t0 = cyc;
      step(idle, wr(16'h8000, 8'h5A), 1'b0, w);
      step(idle, rd(16'h8000), 1'b0, w);
      repeat (6) step(idle, idle, 1'b0, w);
      check("lit_wr_MW",   32'(log_mw[t0+1]),      32'h1);
      check("lit_wr_MA",   32'(log_ma[t0+1]),      32'h8000);
      check("lit_wr_MDO",  32'(log_mdo[t0+1]),     32'h5A);
      check("lit_wr_MW2",  32'(log_mw[t0+2]),      32'h0);
      check("lit_wr_norv", 32'(log_d_rv[t0+LAT+2]), 32'h0);
      check("lit_raw_rv",  32'(log_d_rv[t0+LAT+3]), 32'h1);
      check("lit_raw_rd",  32'(log_d_rd[t0+LAT+3]), 32'h5A);

      // Reset during an in-flight read drops it; grant resumes right after reset.
      t0 = cyc;
      step(rd(16'h1234), idle, 1'b0, w);
      step(idle, idle, 1'b1, w);
      step(idle, idle, 1'b1, w);
      step(rd(16'h0010), idle, 1'b0, w);
      repeat (6) step(idle, idle, 1'b0, w);
      check("lit_rst_MA",    32'(log_ma[t0+2]),       32'h0);
      check("lit_rst_rd",    32'(log_c_rd[t0+2]),     32'h0);
      check("lit_rst_drop",  32'(log_c_rv[t0+LAT+2]), 32'h0);
      check("lit_rst_gnt",   32'(log_c_gnt[t0+3]),    32'h1);
      check("lit_rst_rv",    32'(log_c_rv[t0+LAT+5]), 32'h1);
      check("lit_rst_data",  32'(log_c_rd[t0+LAT+5]), 32'h11);

      // Idle after a write: MW low, MA holds, starvation count restarts from zero.
      t0 = cyc;
      step(idle, wr(16'h8000, 8'h77), 1'b0, w);
      repeat (10) step(idle, idle, 1'b0, w);
      for (int i = 2; i <= 11; i++) check("lit_idle_MW", 32'(log_mw[t0+i]), 32'h0);
      check("lit_idle_MA", 32'(log_ma[t0+11]), 32'h8000);
      for (int i = 1; i <= 11; i++) check("lit_idle_rv", 32'(log_c_rv[t0+i] | log_d_rv[t0+i]), 32'h0);
      t0 = cyc;
      repeat (5) step(rd(16'h0003), rd(16'h0004), 1'b0, w);
      check("lit_idle_wait3", 32'(log_d_gnt[t0+3]), 32'h0);
      check("lit_idle_wait4", 32'(log_d_gnt[t0+4]), 32'h1);
      repeat (6) step(idle, idle, 1'b0, w);

      // Randomized traffic on a small shared address window.
      cq = '0;
      dq = '0;
      repeat (3000) begin
         if (!cq.req) begin
            if ($urandom_range(0, 9) < 6)
               cq = '{req: 1'b1, addr: 16'($urandom_range(0, 15)), we: 1'($urandom_range(0, 1)), wdata: 8'($urandom)};
         end else if ($urandom_range(0, 9) == 0) cq.req = 1'b0;
         if (!dq.req) begin
            if ($urandom_range(0, 9) < 6)
               dq = '{req: 1'b1, addr: 16'($urandom_range(0, 15)), we: 1'($urandom_range(0, 1)), wdata: 8'($urandom)};
         end else if ($urandom_range(0, 9) == 0) dq.req = 1'b0;
         r = ($urandom_range(0, 299) == 0);
         step(cq, dq, r, w);
         if (w == 1) cq.req = 1'b0;
         if (w == 2) dq.req = 1'b0;
      end
      repeat (8) step(idle, idle, 1'b0, w);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single synchronous memory port between the z80 core and a secondary bus master (DMA or video fetch). It grants at most one access per cycle and drives the registered memory address, data and write strobe. A tag pipeline routes read data back to the requester that issued the read. The core has fixed priority, bounded by a starvation limit for the secondary port.

## Interface
Parameters:
- LATENCY, 1: memory read latency in cycles (legal 1..4). MDI carries the data for the address presented in cycle K during cycle K+LATENCY.
- STARVE, 4: maximum number of consecutive lost arbitrations for the D port (legal 1..15).

Ports:
- CLOCK in 1: single clock; all state updates on its rising edge.
- RESET in 1: synchronous, active-high reset.
- c_req in 1: core request; the core holds it high with c_addr/c_we/c_wdata stable until c_gnt.
- c_addr in 16: core address.
- c_we in 1: 1=write, 0=read.
- c_wdata in 8: core write data.
- c_gnt out 1: combinational grant, same cycle as the accepted request.
- c_rvalid out 1: one-cycle strobe; c_rdata is valid.
- c_rdata out 8: read data.
- d_req, d_addr[16], d_we, d_wdata[8], d_gnt, d_rvalid, d_rdata[8]: secondary port, identical semantics.
- MA out 16: memory address (registered).
- MDO out 8: memory write data (registered).
- MW out 1: memory write enable (registered).
- MDI in 8: memory read data.

## Operation
- Arbitration is evaluated each cycle:
  - Only one req high: that port wins.
  - Both high and wait_cnt < STARVE: C wins.
  - Both high and wait_cnt == STARVE: D wins.
- The winning port's gnt is asserted. The loser's gnt is 0. Both gnts are 0 while RESET=1.
- wait_cnt (4 bits):
  - Increments when d_req=1 and d_gnt=0.
  - Clears when d_gnt=1 or d_req=0.
  - Saturates at STARVE.
- Issue stage (edge ending the grant cycle):
  - MA <= winner addr, MDO <= winner wdata, MW <= winner we.
  - With no grant: MW <= 0, MA and MDO hold.
- Tag pipeline:
  - Depth LATENCY+1 shift register of {valid, port}.
  - Entry valid only for a granted read.
  - Writes and idle cycles insert invalid entries.
- Return stage:
  - When the tail entry is valid, MDI is registered into the tagged port's rdata and that port's rvalid pulses for one cycle.
  - The other port's rvalid is 0 and its rdata holds.
- c_rvalid and d_rvalid are never high together. At most one return occurs per cycle, because at most one issue occurs per cycle.
- Read-after-write to the same address on consecutive grants returns the new data. The memory is write-first, so the arbiter adds no hazard logic.

## Timing
- Grant: cycle N (combinational from req).
- Memory access: MA/MW valid in cycle N+1. MW is high for exactly one cycle per granted write.
- Read return: MDI valid in N+1+LATENCY. rvalid and rdata are valid in N+2+LATENCY, a total read latency of LATENCY+2 cycles from grant.
- Throughput: one access per cycle sustained. Back-to-back grants to alternating ports return in issue order.
- Reset values: MA=0, MDO=0, MW=0, c_rvalid=d_rvalid=0, c_rdata=d_rdata=0, wait_cnt=0, all tag entries invalid.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them. The first grant possible is in the cycle after RESET deasserts.
- A requester dropping req before gnt is legal and has no side effects. wait_cnt clears in that case.

## Test plan
- CPU read, LATENCY=1: c_req=1, c_addr=0x1234 in cycle 0 -> c_gnt=1 in cycle 0; MA=0x1234, MW=0 in cycle 1; memory model returns 0xA5 -> c_rvalid=1, c_rdata=0xA5 in cycle 3 only; d_rvalid stays 0.
- Contention, STARVE=4: c_req and d_req held high from cycle 0 -> c_gnt in cycles 0-3; d_gnt in cycle 4; c_gnt in cycles 5-8; d_gnt in cycle 9.
- Mixed pipeline, LATENCY=2: C reads 0x0010 (data 0x11) in cycle 0, D reads 0x0020 (data 0x22) in cycle 1 -> c_rvalid with 0x11 in cycle 4; d_rvalid with 0x22 in cycle 5.
- Write then read: D writes 0x5A to 0x8000 in cycle 0, then D reads 0x8000 in cycle 1 -> MW=1, MA=0x8000, MDO=0x5A in cycle 1 only; write produces no rvalid; d_rvalid with d_rdata=0x5A in cycle 1+LATENCY+2.
- Reset mid-read: C read granted in cycle 0, RESET=1 in cycle 1 -> no c_rvalid ever; all outputs 0 while reset; new grant possible in the first cycle after reset.
- Idle: no req for 10 cycles after a write -> MW=0, MA holds the last address, no rvalid, wait_cnt=0.
